// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: shared widths, FSM states and latency bounds for the memory responder
package cache_mem_pkg;
   localparam int ADR_W = 6;
   localparam int DATA_W = 8;
   localparam int LATENCY_MAX = 15;
   localparam int CNT_W = $clog2(LATENCY_MAX + 1);
   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, HOLD = 2'd3} state_t;
endpackage

// File: rtl/cache_mem_responder_if.sv
// cache_mem_responder_if: cache-to-memory request/response bundle
interface cache_mem_responder_if;
   import cache_mem_pkg::*;
   logic              rd_en;
   logic [ADR_W-1:0]  rd_adr;
   logic              wr_en;
   logic [ADR_W-1:0]  wr_adr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] mem_data;
   logic              rd_valid;
   logic              wr_done;
   logic              busy;
   modport master (output rd_en, rd_adr, wr_en, wr_adr, wr_data,
                   input mem_data, rd_valid, wr_done, busy);
   modport slave (input rd_en, rd_adr, wr_en, wr_adr, wr_data,
                  output mem_data, rd_valid, wr_done, busy);
endinterface

// File: rtl/mem_array.sv
// mem_array: 64 x 8 storage, synchronous write, asynchronous read, no reset
module mem_array import cache_mem_pkg::*; (
   input  logic              clk,
   input  logic              we,
   input  logic [ADR_W-1:0]  wadr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADR_W-1:0]  radr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADR_W];
   always_ff @(posedge clk)
      if (we) mem[wadr] <= wdata;
   assign rdata = mem[radr];
endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: fixed-latency backing store serving cache fills and write-backs
module cache_mem_responder import cache_mem_pkg::*; #(
   parameter int LATENCY = 4
) (
   input  logic clk,
   input  logic reset,
   cache_mem_responder_if.slave bus
);
   localparam logic [CNT_W-1:0] LAT1 = CNT_W'(LATENCY - 1);
   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              pend, pend_d;
   logic              lat_w, lat_r, we, rd_fire;
   logic [ADR_W-1:0]  wadr_q, radr_q;
   logic [DATA_W-1:0] wdata_q, rdata;
   mem_array u_mem (
      .clk(clk), .we(we), .wadr(wadr_q), .wdata(wdata_q), .radr(radr_q), .rdata(rdata)
   );
   // write-back wins on simultaneous requests so the victim leaves before the fill
   always_comb begin
      state_d = state;
      cnt_d = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
      pend_d = pend;
      lat_w = 1'b0;
      lat_r = 1'b0;
      we = 1'b0;
      rd_fire = 1'b0;
      case (state)
         IDLE:
            if (bus.wr_en) begin
               state_d = WRITE;
               cnt_d = LAT1;
               lat_w = 1'b1;
               lat_r = 1'b1;
               pend_d = bus.rd_en;
            end else if (bus.rd_en) begin
               state_d = READ;
               cnt_d = LAT1;
               lat_r = 1'b1;
            end
         WRITE:
            if (cnt == '0) begin
               we = 1'b1;
               state_d = pend ? READ : HOLD;
               cnt_d = LAT1;
            end
         READ:
            if (cnt == '0) begin
               rd_fire = 1'b1;
               pend_d = 1'b0;
               state_d = HOLD;
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         pend <= 1'b0;
         wadr_q <= '0;
         wdata_q <= '0;
         radr_q <= '0;
         bus.mem_data <= '0;
         bus.rd_valid <= 1'b0;
         bus.wr_done <= 1'b0;
      end else begin
         state <= state_d;
         cnt <= cnt_d;
         pend <= pend_d;
         if (lat_w) wadr_q <= bus.wr_adr;
         if (lat_w) wdata_q <= bus.wr_data;
         if (lat_r) radr_q <= bus.rd_adr;
         if (rd_fire) bus.mem_data <= rdata;
         bus.rd_valid <= rd_fire;
         bus.wr_done <= we;
      end
   assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: directed bench with a cycle-level response model
module tb_cache_mem_responder;
   localparam int LAT = 4;
   logic clk = 1'b0;
   logic reset;
   int cyc = 0;
   int nchk = 0;
   int nerr = 0;
   int exp_bs = -1, exp_be = -1, exp_wd = -1, exp_rv = -1;
   logic [7:0] rv_data = 8'h00;
   logic [7:0] md_model = 8'h00;
   logic [7:0] model_mem [64];
   cache_mem_responder_if bus ();
   cache_mem_responder #(.LATENCY(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d actual=%02h required=%02h", name, cyc, act, exp);
      end
   endtask
   // expected outputs follow from request time alone: pulses at k+L (and k+2L for a fill behind a write-back)
   always @(posedge clk) begin
      #1;
      if (!reset) md_model = 8'h00;
      else if (cyc == exp_rv) md_model = rv_data;
      chk("busy", 8'(bus.busy), 8'(reset && exp_bs >= 0 && cyc >= exp_bs && cyc <= exp_be));
      chk("wr_done", 8'(bus.wr_done), 8'(reset && cyc == exp_wd));
      chk("rd_valid", 8'(bus.rd_valid), 8'(reset && cyc == exp_rv));
      chk("mem_data", bus.mem_data, md_model);
   end
   task automatic txn(input bit w, input bit r, input logic [5:0] wa, input logic [7:0] wd,
                      input logic [5:0] ra, input bit jitter, input bit hold_thru);
      int k;
      @(negedge clk);
      bus.wr_en = w;
      bus.rd_en = r;
      bus.wr_adr = wa;
      bus.wr_data = wd;
      bus.rd_adr = ra;
      k = cyc + 1;
      if (w) model_mem[wa] = wd;
      rv_data = model_mem[ra];
      exp_bs = k;
      exp_be = k + ((w && r) ? 2 * LAT : LAT);
      exp_wd = w ? k + LAT : -1;
      exp_rv = r ? (w ? k + 2 * LAT : k + LAT) : -1;
      while (cyc < exp_be + int'(hold_thru)) begin
         @(negedge clk);
         if (jitter) begin
            bus.rd_adr = 6'($urandom);
            bus.wr_adr = 6'($urandom);
            bus.wr_data = 8'($urandom);
         end
      end
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask
   initial begin
      #100000;
      $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
      $fatal(1);
   end
   initial begin
      int k;
      reset = 1'b0;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_adr = '0;
      bus.wr_adr = '0;
      bus.wr_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_mem_data", bus.mem_data, 8'h00);
      chk("rst_rd_valid", 8'(bus.rd_valid), 8'h00);
      chk("rst_wr_done", 8'(bus.wr_done), 8'h00);
      chk("rst_busy", 8'(bus.busy), 8'h00);
      reset = 1'b1;
      txn(1, 0, 6'h2A, 8'h5C, 6'h00, 0, 0);
      txn(0, 1, 6'h00, 8'h00, 6'h2A, 0, 0);
      chk("lit_rd_2a", bus.mem_data, 8'h5C);
      txn(1, 1, 6'h13, 8'hA7, 6'h13, 0, 0);
      chk("lit_raw_13", bus.mem_data, 8'hA7);
      txn(1, 1, 6'h20, 8'h3D, 6'h2A, 1, 1);
      chk("lit_jit_2a", bus.mem_data, 8'h5C);
      txn(0, 1, 6'h00, 8'h00, 6'h20, 1, 1);
      chk("lit_jit_20", bus.mem_data, 8'h3D);
      txn(1, 0, 6'h05, 8'h11, 6'h00, 0, 0);
      @(negedge clk);
      bus.wr_en = 1'b1;
      bus.wr_adr = 6'h05;
      bus.wr_data = 8'hFF;
      k = cyc + 1;
      exp_bs = k;
      exp_be = k + LAT;
      exp_wd = -1;
      exp_rv = -1;
      while (cyc < k + 2) @(posedge clk);
      #2;
      reset = 1'b0;
      bus.wr_en = 1'b0;
      exp_bs = -1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      txn(0, 1, 6'h00, 8'h00, 6'h05, 0, 0);
      chk("lit_abort_05", bus.mem_data, 8'h11);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Main-memory side of the cache-to-memory interface: a 64 x 8 backing store with a fixed, configurable access latency.
- Serves line fills (read requests) and dirty-victim write-backs (write requests) issued by the 2-way cache.
- Returns fill data on mem_data with a one-cycle valid pulse, and acknowledges write-backs with a one-cycle done pulse.
- Sits directly below the cache; it is the responder for the cache's cache2mem_* request signals.

Parameters:
- ADR_W, 6, address width (64 locations, {tag[2:0], index[2:0]}).
- DATA_W, 8, data width.
- LATENCY, 4, cycles from request sampling to response pulse; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low (0 = reset asserted).
- rd_en  input  1  fill request, connected to cache2mem_read_enable.
- rd_adr  input  ADR_W  fill address, connected to cache2memread_adr.
- wr_en  input  1  write-back request, connected to cache2mem_write_enable.
- wr_adr  input  ADR_W  write-back address, connected to cache2memorywrite_adr.
- wr_data  input  DATA_W  write-back data, connected to cache2memwrite_data.
- mem_data  output  DATA_W  fill data; holds its value until the next read completes.
- rd_valid  output  1  one-cycle pulse: mem_data carries the requested word.
- wr_done  output  1  one-cycle pulse: the write-back has been committed to the array.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, pending-read flag=0.
  - mem_data=0, rd_valid=0, wr_done=0, busy=0.
  - Array contents are not reset.
  - Asserting reset mid-operation aborts the operation: an in-flight write is not committed and no pulse is issued.
- States: IDLE, WRITE, READ, HOLD.
- IDLE, evaluated at the rising edge:
  - wr_en=1: latch wr_adr and wr_data; also latch rd_en into the pending flag and rd_adr into the read-address register. Load counter with LATENCY-1 and go to WRITE.
  - Else rd_en=1: latch rd_adr, load counter with LATENCY-1, go to READ.
  - Else stay in IDLE.
  - Write-back priority on simultaneous requests is mandatory: the victim is evicted before the fill.
- WRITE:
  - Decrement the counter each cycle while it is nonzero.
  - On the edge where counter==0: write the array at the latched address, assert wr_done for the following cycle, and go to READ (counter reloaded to LATENCY-1) if pending=1, else to HOLD.
- READ:
  - Decrement the counter each cycle while it is nonzero.
  - On the edge where counter==0: mem_data <= array[latched rd_adr], assert rd_valid for the following cycle, clear pending, go to HOLD.
- HOLD:
  - Lasts one cycle; requests are ignored; next state is IDLE.
  - This gives the requester one cycle to drop its level-sensitive enables after consuming the response.
- Latency: if a request is sampled at edge k, the array write or mem_data update occurs at edge k+LATENCY, and the pulse is high during cycle k+LATENCY.
  - Combined write-back followed by fill: rd_valid is high during cycle k+2*LATENCY.
- Input changes while busy=1 are ignored. The requester must hold its enables until it sees the pulse.
- Read-after-write to the same address within a combined request returns the newly written data.
- Counter width is 4 bits; the counter never wraps because it is reloaded only on entry to WRITE or READ.
- rd_valid and wr_done are never high in the same cycle.

Decomposition:
- Package cache_mem_pkg: ADR_W, DATA_W, state enum (IDLE=2'd0, WRITE=2'd1, READ=2'd2, HOLD=2'd3), LATENCY_MAX=15.
- Sub-module mem_array: synchronous-write, asynchronous-read 64 x 8 storage with ports we, wadr, wdata, radr, rdata. It has no reset.
- FSM, counter and output registers live in cache_mem_responder.

Test Plan:
- Reset, then hold reset=0 for 3 cycles -> mem_data=0, rd_valid=0, wr_done=0, busy=0.
- Write-only, LATENCY=4: wr_en=1, wr_adr=6'h2A, wr_data=8'h5C, sampled at edge k -> busy=1 from k, wr_done pulses exactly in cycle k+4, HOLD one cycle, then IDLE.
- Read-only after that write: rd_en=1, rd_adr=6'h2A -> rd_valid pulses in cycle k+4 with mem_data=8'h5C; mem_data stays 8'h5C after the pulse.
- Combined eviction and fill: wr_en=1 (adr 6'h13, data 8'hA7) and rd_en=1 (adr 6'h13) in the same cycle -> wr_done at k+4, rd_valid at k+8 with mem_data=8'hA7.
- Ignored inputs: while busy, toggle rd_adr and wr_data randomly -> response uses only the values latched at sampling; enables held high through HOLD cause no re-issue until IDLE.
- Reset mid-write: assert reset=0 at k+2 of a write of 8'hFF to 6'h05 -> no wr_done; a subsequent read of 6'h05 returns the prior content.
